// File: rtl/led_pwm_driver.sv
// led_pwm_driver: double-buffered per-frame PWM stage with global brightness for the board LEDs.
// Optional blink gating is built only when LED_PWM_BLINK_EN is defined.  Rev 1.0
`default_nettype none

module led_pwm_driver #(
    parameter int NUM_LEDS     = 10,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         led_in,
    input  logic [15:0]         bright_in,
    input  logic                bright_load,
    output logic [NUM_LEDS-1:0] led_out,
    output logic [15:0]         bright_out,
    output logic                frame_tick
);

    localparam int                  PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PRE_W-1:0]    pre_cnt_q,  pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_reg_q, duty_reg_d;
    logic [PWM_BITS-1:0] duty_sh_q,  duty_sh_d;
    logic [NUM_LEDS-1:0] mask_sh_q,  mask_sh_d;
    logic [NUM_LEDS-1:0] led_out_q,  led_out_d;
    logic                frame_tick_q, frame_tick_d;
    logic                step;
    logic                frame_end;
    logic                pwm_on;
    logic [15:0]         bright_rd;

`ifdef LED_PWM_BLINK_EN
    localparam int               FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic             blink_en_q,  blink_en_d;
    logic             blink_off_q, blink_off_d;
    logic [FRM_W-1:0] frm_cnt_q,   frm_cnt_d;
`endif

    always_comb begin
        step         = (pre_cnt_q == PRE_LAST);
        frame_end    = step && (pwm_cnt_q == DUTY_MAX);
        pre_cnt_d    = step ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d    = step ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        // Shadows reload only at the frame edge, so the old duty_reg wins a same-cycle write.
        mask_sh_d    = frame_end ? led_in[NUM_LEDS-1:0] : mask_sh_q;
        duty_sh_d    = frame_end ? duty_reg_q : duty_sh_q;
        duty_reg_d   = bright_load ? bright_in[PWM_BITS-1:0] : duty_reg_q;
        frame_tick_d = frame_end;
        // Full-scale duty is forced on so there is no one-step dark gap per frame.
        pwm_on       = (duty_sh_q == DUTY_MAX) || (pwm_cnt_q < duty_sh_q);
        led_out_d    = pwm_on ? mask_sh_q : '0;
        bright_rd    = 16'(duty_reg_q);
`ifdef LED_PWM_BLINK_EN
        blink_en_d   = bright_load ? bright_in[15] : blink_en_q;
        blink_off_d  = blink_off_q;
        frm_cnt_d    = frm_cnt_q;
        if (frame_tick_q) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d   = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                frm_cnt_d   = frm_cnt_q + 1'b1;
            end
        end
        if (blink_en_q && blink_off_q) begin
            led_out_d = '0;
        end
        bright_rd[15] = blink_en_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q    <= '0;
            pwm_cnt_q    <= '0;
            duty_reg_q   <= '1;
            duty_sh_q    <= '1;
            mask_sh_q    <= '0;
            led_out_q    <= '0;
            frame_tick_q <= 1'b0;
`ifdef LED_PWM_BLINK_EN
            blink_en_q   <= 1'b0;
            blink_off_q  <= 1'b0;
            frm_cnt_q    <= '0;
`endif
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            duty_reg_q   <= duty_reg_d;
            duty_sh_q    <= duty_sh_d;
            mask_sh_q    <= mask_sh_d;
            led_out_q    <= led_out_d;
            frame_tick_q <= frame_tick_d;
`ifdef LED_PWM_BLINK_EN
            blink_en_q   <= blink_en_d;
            blink_off_q  <= blink_off_d;
            frm_cnt_q    <= frm_cnt_d;
`endif
        end
    end

    assign led_out    = led_out_q;
    assign frame_tick = frame_tick_q;
    assign bright_out = bright_rd;

    logic unused_bits;
    assign unused_bits = ^{led_in, bright_in};

endmodule

`default_nettype wire
